// File: rtl/spi_ctrl_pkg.sv
// Shared types and helpers for the SPI controller family.
package spi_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} arb_state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // Index of the set bit in a one-hot vector of up to eight requesters.
    function automatic logic [2:0] onehot_to_index(input logic [7:0] onehot);
        logic [2:0] index;
        index = '0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) begin
                index = 3'(i);
            end
        end
        return index;
    endfunction

endpackage

// File: rtl/spi_xfer_arbiter_if.sv
// Client-side and SPI-master-side signals of the transfer arbiter.
interface spi_xfer_arbiter_if
    import spi_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          rsp_err;
    logic [NUM_REQ-1:0]            cs_n;
    logic                          busy;
    logic [DATA_WIDTH-1:0]         m_d_in;
    logic                          m_send_data;
    logic [DATA_WIDTH-1:0]         m_d_out;
    logic                          m_d_out_valid;

    modport master (
        output req, req_data, m_d_out, m_d_out_valid,
        input  gnt, rsp_valid, rsp_data, rsp_err, cs_n, busy, m_d_in, m_send_data
    );

    modport slave (
        input  req, req_data, m_d_out, m_d_out_valid,
        output gnt, rsp_valid, rsp_data, rsp_err, cs_n, busy, m_d_in, m_send_data
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester above ptr, wrapping.
module rr_pick
    import spi_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   winner
);

    logic [NUM_REQ-1:0] onehot;
    logic               found;

    // Upper pass covers ptr+1..top, lower pass wraps back to 0..ptr.
    always_comb begin
        onehot = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i > int'(ptr))) begin
                onehot[i] = 1'b1;
                found     = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i <= int'(ptr))) begin
                onehot[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign any    = |req;
    assign winner = IDX_W'(onehot_to_index(8'(onehot)));

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one SPI master byte engine among NUM_REQ clients, one transfer at a time.
module spi_xfer_arbiter
    import spi_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int GAP_CYCLES     = 2
) (
    input logic              clk,
    input logic              reset,
    spi_xfer_arbiter_if.slave bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW    = $clog2(GAP_CYCLES + 1);

    arb_state_t            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d, ptr_q, ptr_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d, cs_n_q, cs_n_d, rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d, m_d_in_q, m_d_in_d;
    logic                  rsp_err_q, rsp_err_d, send_q, send_d, busy_q, busy_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic [GW-1:0]         gcnt_q, gcnt_d;
    logic                  any;
    logic [IDX_W-1:0]      winner;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .any    (any),
        .winner (winner)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            gnt_q       <= '0;
            cs_n_q      <= '1;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            m_d_in_q    <= '0;
            send_q      <= 1'b0;
            busy_q      <= 1'b0;
            tcnt_q      <= '0;
            gcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            cs_n_q      <= cs_n_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            m_d_in_q    <= m_d_in_d;
            send_q      <= send_d;
            busy_q      <= busy_d;
            tcnt_q      <= tcnt_d;
            gcnt_q      <= gcnt_d;
        end
    end

    // Response pulses and the send strobe default low; everything else holds.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        cs_n_d      = cs_n_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = 1'b0;
        m_d_in_d    = m_d_in_q;
        send_d      = 1'b0;
        tcnt_d      = tcnt_q;
        gcnt_d      = gcnt_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    idx_d          = winner;
                    ptr_d          = winner;
                    gnt_d          = '0;
                    gnt_d[winner]  = 1'b1;
                    cs_n_d         = '1;
                    cs_n_d[winner] = 1'b0;
                    m_d_in_d       = bus.req_data[winner*DATA_WIDTH +: DATA_WIDTH];
                    send_d         = 1'b1;
                    state_d        = START;
                end
            end
            START: begin
                tcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A valid byte on the final cycle beats the timeout.
                if (bus.m_d_out_valid) begin
                    rsp_data_d         = bus.m_d_out;
                    rsp_valid_d[idx_q] = 1'b1;
                    gnt_d              = '0;
                    cs_n_d             = '1;
                    gcnt_d             = '0;
                    state_d            = GAP;
                end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_data_d         = '0;
                    rsp_err_d          = 1'b1;
                    rsp_valid_d[idx_q] = 1'b1;
                    gnt_d              = '0;
                    cs_n_d             = '1;
                    gcnt_d             = '0;
                    state_d            = GAP;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            GAP: begin
                if (gcnt_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign bus.gnt         = gnt_q;
    assign bus.cs_n        = cs_n_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.m_d_in      = m_d_in_q;
    assign bus.m_send_data = send_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter: vector table of transfers plus corner sequences.
module tb_spi_xfer_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 8;
    localparam int TO      = 255;
    localparam int GAPC    = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_xfer_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) bus ();

    spi_xfer_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAPC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rst_first;
        logic [3:0]  req;
        logic [31:0] data;
        int          lat;
        int          dly;
        logic [7:0]  dout;
        logic [3:0]  exp_gnt;
        logic [7:0]  exp_din;
    } vec_t;

    vec_t vecs[9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d);
        bus.req      = r;
        bus.req_data = d;
    endtask

    task automatic doReset();
        reset             = 1'b1;
        bus.req           = '0;
        bus.m_d_out_valid = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic waitSend(output int n);
        n = 0;
        while (bus.m_send_data !== 1'b1 && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic runVec(input vec_t v);
        int n;
        if (v.rst_first) doReset();
        applyStimulus(v.req, v.data);
        waitSend(n);
        checkOutput("grant_latency", 32'(n), 32'(v.lat));
        checkOutput("gnt", 32'(bus.gnt), 32'(v.exp_gnt));
        checkOutput("cs_n_active", 32'(bus.cs_n), 32'(4'(~v.exp_gnt)));
        checkOutput("m_d_in", 32'(bus.m_d_in), 32'(v.exp_din));
        checkOutput("busy", 32'(bus.busy), 32'd1);
        step();
        checkOutput("send_pulse_width", 32'(bus.m_send_data), 32'd0);
        checkOutput("cs_n_wait", 32'(bus.cs_n), 32'(4'(~v.exp_gnt)));
        for (int i = 1; i < v.dly; i++) step();
        bus.m_d_out       = v.dout;
        bus.m_d_out_valid = 1'b1;
        step();
        bus.m_d_out_valid = 1'b0;
        checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(v.exp_gnt));
        checkOutput("rsp_data", 32'(bus.rsp_data), 32'(v.dout));
        checkOutput("rsp_err", 32'(bus.rsp_err), 32'd0);
        checkOutput("cs_n_release", 32'(bus.cs_n), 32'hF);
        checkOutput("gnt_release", 32'(bus.gnt), 32'd0);
        checkOutput("m_d_in_hold", 32'(bus.m_d_in), 32'(v.exp_din));
        step();
        checkOutput("rsp_valid_clear", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        int n;
        reset             = 1'b1;
        bus.req           = '0;
        bus.req_data      = '0;
        bus.m_d_out       = '0;
        bus.m_d_out_valid = 1'b0;

        vecs[0] = '{1'b1, 4'b0001, 32'h000000A5, 1, 10, 8'h3C, 4'b0001, 8'hA5};
        vecs[1] = '{1'b1, 4'b1111, 32'h44332211, 1, 3,  8'h81, 4'b0001, 8'h11};
        vecs[2] = '{1'b0, 4'b1111, 32'h44332211, 2, 5,  8'h82, 4'b0010, 8'h22};
        vecs[3] = '{1'b0, 4'b1111, 32'h44332211, 2, 1,  8'h83, 4'b0100, 8'h33};
        vecs[4] = '{1'b0, 4'b1111, 32'h44332211, 2, 7,  8'h84, 4'b1000, 8'h44};
        vecs[5] = '{1'b0, 4'b1111, 32'h44332211, 2, 2,  8'h85, 4'b0001, 8'h11};
        vecs[6] = '{1'b0, 4'b1010, 32'h44332211, 2, 4,  8'h86, 4'b0010, 8'h22};
        vecs[7] = '{1'b0, 4'b1010, 32'h44332211, 2, 6,  8'h87, 4'b1000, 8'h44};
        vecs[8] = '{1'b0, 4'b1010, 32'h44332211, 2, 3,  8'h88, 4'b0010, 8'h22};

        #2;
        checkOutput("reset_gnt", 32'(bus.gnt), 32'd0);
        checkOutput("reset_cs_n", 32'(bus.cs_n), 32'hF);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
        checkOutput("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        checkOutput("reset_m_d_in", 32'(bus.m_d_in), 32'd0);
        checkOutput("reset_send", 32'(bus.m_send_data), 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        step();
        reset = 1'b0;

        for (int k = 0; k < 9; k++) runVec(vecs[k]);

        // Timeout: requester 2, master never answers
        doReset();
        applyStimulus(4'b0100, 32'h44332211);
        waitSend(n);
        checkOutput("to_latency", 32'(n), 32'd1);
        checkOutput("to_gnt", 32'(bus.gnt), 32'b0100);
        n = 0;
        while (bus.rsp_valid === 4'b0000 && n < 400) begin
            step();
            n++;
        end
        checkOutput("to_cycles", 32'(n), 32'(TO + 1));
        checkOutput("to_rsp_valid", 32'(bus.rsp_valid), 32'b0100);
        checkOutput("to_rsp_err", 32'(bus.rsp_err), 32'd1);
        checkOutput("to_rsp_data", 32'(bus.rsp_data), 32'd0);
        checkOutput("to_cs_n", 32'(bus.cs_n), 32'hF);
        step();
        checkOutput("to_err_clear", 32'(bus.rsp_err), 32'd0);

        // Valid arrives on the final WAIT cycle: valid wins
        waitSend(n);
        checkOutput("co_latency", 32'(n), 32'd2);
        for (int i = 0; i < TO; i++) step();
        checkOutput("co_not_early", 32'(bus.rsp_valid), 32'd0);
        bus.m_d_out       = 8'h5A;
        bus.m_d_out_valid = 1'b1;
        step();
        bus.m_d_out_valid = 1'b0;
        checkOutput("co_rsp_valid", 32'(bus.rsp_valid), 32'b0100);
        checkOutput("co_rsp_err", 32'(bus.rsp_err), 32'd0);
        checkOutput("co_rsp_data", 32'(bus.rsp_data), 32'h5A);

        // Requester 1 drops req mid-transfer; extra valid cycle is ignored
        doReset();
        applyStimulus(4'b0010, 32'h44332211);
        waitSend(n);
        checkOutput("drop_gnt", 32'(bus.gnt), 32'b0010);
        checkOutput("drop_m_d_in", 32'(bus.m_d_in), 32'h22);
        step();
        step();
        bus.req = 4'b0000;
        step();
        step();
        bus.m_d_out       = 8'h77;
        bus.m_d_out_valid = 1'b1;
        step();
        checkOutput("drop_rsp_valid", 32'(bus.rsp_valid), 32'b0010);
        checkOutput("drop_rsp_data", 32'(bus.rsp_data), 32'h77);
        bus.m_d_out = 8'h99;
        step();
        bus.m_d_out_valid = 1'b0;
        checkOutput("extra_valid_ignored", 32'(bus.rsp_valid), 32'd0);
        checkOutput("extra_data_ignored", 32'(bus.rsp_data), 32'h77);
        step();
        step();
        checkOutput("idle_busy", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of WAIT
        applyStimulus(4'b0001, 32'h44332211);
        waitSend(n);
        step();
        step();
        reset = 1'b1;
        applyStimulus(4'b1010, 32'h44332211);
        #1;
        checkOutput("async_gnt", 32'(bus.gnt), 32'd0);
        checkOutput("async_cs_n", 32'(bus.cs_n), 32'hF);
        checkOutput("async_busy", 32'(bus.busy), 32'd0);
        checkOutput("async_send", 32'(bus.m_send_data), 32'd0);
        step();
        reset = 1'b0;
        step();
        checkOutput("post_reset_gnt", 32'(bus.gnt), 32'b0010);
        checkOutput("post_reset_send", 32'(bus.m_send_data), 32'd1);
        checkOutput("post_reset_m_d_in", 32'(bus.m_d_in), 32'h22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
